pipe_hazard_ctrl: RTL and testbench

- Central stall, flush and forwarding sequencer for the 5-stage pipeline: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Detects load-use hazards and selects ID-stage operand forwarding.
- Squashes the fetch slot on branch/jump redirect.
- Runs the req/ack handshake to a multi-cycle data memory: freezes the upstream pipeline and bubbles MEM/WB while the access is pending.
- Counts stall cycles; detects memory timeouts.

---
 rtl/pipe_hazard_ctrl_if.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/acknowledge handshake between the hazard controller and the multi-cycle data memory.
// The controller holds the master side and raises dmem_req; the memory answers with dmem_ack.
interface pipe_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ack;

    modport master (
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding sequencer for a 5-stage pipeline with a multi-cycle data memory.
// Priority is mem stall > load-use > redirect; forwarding is purely combinational.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_redirect,
    input  logic [4:0]         e_rn,
    input  logic               e_wreg,
    input  logic               e_m2reg,
    input  logic [4:0]         m_rn,
    input  logic               m_wreg,
    input  logic               m_m2reg,
    input  logic               m_mem_access,
    pipe_hazard_ctrl_if.master dmem,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               if_id_flush,
    output logic               id_ex_en,
    output logic               id_ex_bubble,
    output logic               ex_mem_en,
    output logic               mem_wb_bubble,
    output logic [1:0]         fwda,
    output logic [1:0]         fwdb,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               mem_timeout
);

    localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               timeout_q, timeout_d;
    logic               mem_stall;
    logic               lu;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] ern, input logic ewreg, input logic em2reg,
        input logic [4:0] mrn, input logic mwreg, input logic mm2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ewreg && ern != 5'd0 && ern == src && !em2reg) begin
            sel = 2'b01;
        end else if (mwreg && mrn != 5'd0 && mrn == src) begin
            sel = mm2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    assign lu = e_wreg && e_m2reg && (e_rn != 5'd0) &&
                ((id_use_rs && id_rs == e_rn) || (id_use_rt && id_rt == e_rn));

    // Memory FSM: next state, request and stall decision
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        dmem.dmem_req = 1'b0;
        mem_stall     = 1'b0;
        unique case (state_q)
            StRun: begin
                dmem.dmem_req = m_mem_access;
                if (m_mem_access && !dmem.dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                dmem.dmem_req = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == WaitW'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = StHalt;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                end
            end
            StHalt: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = id_redirect;
        end
    end

    always_comb begin
        fwda = fwd_sel(id_rs, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);
        fwdb = fwd_sel(id_rt, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);
    end

    // Saturating: stays at all-ones once reached
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the combinational decode plus
// hand-written sequences for memory wait, reset, redirect/load-use interplay and timeout.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CntW = 16;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       use_rs;
        logic       use_rt;
        logic       redir;
        logic [4:0] e_rn;
        logic       e_wreg;
        logic       e_m2reg;
        logic [4:0] m_rn;
        logic       m_wreg;
        logic       m_m2reg;
        logic       acc;
        logic       ack;
        logic [7:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    // ctl bits: {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
    localparam logic [7:0] CRun = 8'b0110_1010;
    localparam logic [7:0] CLu  = 8'b0000_1110;
    localparam logic [7:0] CFl  = 8'b0111_1010;
    localparam logic [7:0] CZw  = 8'b1110_1010;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      id_rs, id_rt, e_rn, m_rn;
    logic            id_use_rs, id_use_rt, id_redirect;
    logic            e_wreg, e_m2reg, m_wreg, m_m2reg, m_mem_access;
    logic            pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
    logic            mem_wb_bubble, mem_timeout;
    logic [1:0]      fwda, fwdb;
    logic [CntW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [14];

    pipe_hazard_ctrl_if dmem_bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (CntW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_redirect   (id_redirect),
        .e_rn          (e_rn),
        .e_wreg        (e_wreg),
        .e_m2reg       (e_m2reg),
        .m_rn          (m_rn),
        .m_wreg        (m_wreg),
        .m_m2reg       (m_m2reg),
        .m_mem_access  (m_mem_access),
        .dmem          (dmem_bus.master),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_bubble (mem_wb_bubble),
        .fwda          (fwda),
        .fwdb          (fwdb),
        .stall_cnt     (stall_cnt),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ctl_now();
        return {dmem_bus.dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                ex_mem_en, mem_wb_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic zero_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_redirect = 1'b0;
        e_rn = 5'd0; e_wreg = 1'b0; e_m2reg = 1'b0;
        m_rn = 5'd0; m_wreg = 1'b0; m_m2reg = 1'b0;
        m_mem_access = 1'b0; dmem_bus.dmem_ack = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        id_redirect = v.redir;
        e_rn = v.e_rn; e_wreg = v.e_wreg; e_m2reg = v.e_m2reg;
        m_rn = v.m_rn; m_wreg = v.m_wreg; m_m2reg = v.m_m2reg;
        m_mem_access = v.acc; dmem_bus.dmem_ack = v.ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_load_use5();
        e_rn = 5'd5; e_wreg = 1'b1; e_m2reg = 1'b1;
        id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    initial begin
        //          rs     rt     urs   urt   rdr   ern    ew    em    mrn    mw    mm    acc   ack   ctl   fa     fb
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CRun, 2'b00, 2'b00};
        vecs[1]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, CRun, 2'b00, 2'b01};
        vecs[2]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, CRun, 2'b00, 2'b10};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, CRun, 2'b00, 2'b00};
        vecs[4]  = '{5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, CRun, 2'b11, 2'b11};
        vecs[5]  = '{5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CRun, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CLu,  2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CRun, 2'b00, 2'b00};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CFl,  2'b00, 2'b00};
        vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CLu,  2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, CZw,  2'b00, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, CRun, 2'b00, 2'b00};
        vecs[12] = '{5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, CRun, 2'b10, 2'b00};
        vecs[13] = '{5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, CRun, 2'b01, 2'b01};

        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        #1 check("stall_cnt_in_reset", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_ctl", 32'(ctl_now()), 32'(CRun));
        check("reset_fwd", 32'({fwda, fwdb}), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d_fwda", i), 32'(fwda), 32'(vecs[i].fa));
            check($sformatf("vec%0d_fwdb", i), 32'(fwdb), 32'(vecs[i].fb));
        end
        @(negedge clk);
        zero_inputs();
        #1 check("table_stall_cnt", 32'(stall_cnt), 32'd2);

        // Load-use, then the load moves into MEM and is forwarded from mmo
        do_reset();
        set_load_use5();
        #1 check("lu_ctl", 32'(ctl_now()), 32'(CLu));
        @(negedge clk);
        e_rn = 5'd0; e_wreg = 1'b0; e_m2reg = 1'b0;
        m_rn = 5'd5; m_wreg = 1'b1; m_m2reg = 1'b1;
        #1;
        check("lu_next_fwda", 32'(fwda), 32'd3);
        check("lu_next_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_next_pc_en", 32'(pc_en), 32'd1);

        // Memory wait with ack three cycles after the request
        do_reset();
        m_mem_access = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                set_load_use5();
                id_redirect = 1'b1;
            end else begin
                e_rn = 5'd0; e_wreg = 1'b0; e_m2reg = 1'b0;
                id_rs = 5'd0; id_use_rs = 1'b0; id_redirect = 1'b0;
            end
            #1 check($sformatf("memwait_c%0d_ctl", c), 32'(ctl_now()), 32'b1000_0001);
            @(negedge clk);
        end
        dmem_bus.dmem_ack = 1'b1;
        #1 check("memwait_ack_ctl", 32'(ctl_now()), 32'(CZw));
        @(negedge clk);
        zero_inputs();
        #1;
        check("memwait_done_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("memwait_stall_cnt", 32'(stall_cnt), 32'd3);

        // Redirect held back by load-use, then honoured once the hazard clears
        do_reset();
        set_load_use5();
        id_redirect = 1'b1;
        #1 check("redir_lu_flush", 32'(if_id_flush), 32'd0);
        @(negedge clk);
        e_rn = 5'd0; e_wreg = 1'b0; e_m2reg = 1'b0;
        #1 check("redir_next_flush", 32'(if_id_flush), 32'd1);

        // Reset while waiting on memory returns to RUN
        do_reset();
        m_mem_access = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("midwait_req", 32'({dmem_bus.dmem_req, pc_en}), 32'b10);
        rst_n = 1'b0;
        m_mem_access = 1'b0;
        #1 check("midwait_async_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midwait_after_ctl", 32'(ctl_now()), 32'(CRun));
        check("midwait_after_cnt", 32'(stall_cnt), 32'd0);

        // Timeout: ack never comes, HALT is permanent until reset
        do_reset();
        m_mem_access = 1'b1;
        repeat (4) @(negedge clk);
        #1 check("timeout_before", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        #1 check("timeout_set", 32'({mem_timeout, dmem_bus.dmem_req, pc_en}), 32'b100);
        dmem_bus.dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("halt_ctl", 32'({mem_timeout, ctl_now()}), 32'b1_0000_0001);
        do_reset();
        #1 check("halt_reset", 32'({mem_timeout, pc_en}), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
